seven_way_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the 7-input, 1-output select mux among seven requesters. It grants the mux to one requester at a time, holds the grant for that requester's tenure, and drives the mux's 3-bit select. The block sits directly in front of the mux select port: its `sel` output wires to the mux `s` input. Code 3'b111 is never issued.

---
 rtl/seven_way_rr_arbiter.sv | 112 +++++++++++
 tb/tb_seven_way_rr_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_way_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the select of a 7:1 mux (codes 0..6 only).
// Optional forced tenure end after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module seven_way_rr_arbiter #(
  parameter int CNT_W    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       req,
  input  logic             done,
  output logic [6:0]       grant,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           state_reg, state_next;
  logic [6:0]       grant_reg, grant_next;
  logic [2:0]       sel_reg, sel_next;
  logic [2:0]       last_reg, last_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic             timeout_reg, timeout_next;

  logic [2:0] cand [7];
  logic [2:0] winner;
  logic       release_now;
  logic       force_release;

  // cand[gi] is the index visited gi+1 steps after the previous owner, modulo 7
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum      = {1'b0, last_reg} + 4'(gi + 1);
      assign cand[gi] = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
    end
  endgenerate

  always_comb begin
    winner = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (req[cand[i]]) winner = cand[i];
    end
  end

  assign release_now = done | ~req[last_reg];

`ifdef ARB_TIMEOUT_EN
  assign force_release = ~release_now && (hold_reg == CNT_W'(MAX_HOLD - 1));
`else
  assign force_release = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    sel_next     = sel_reg;
    last_next    = last_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = GRANT;
          grant_next = 7'b0000001 << winner;
          sel_next   = winner;
          last_next  = winner;
          hold_next  = '0;
        end
      end
      GRANT: begin
        if (release_now || force_release) begin
          state_next   = TURN;
          grant_next   = '0;
          hold_next    = '0;
          timeout_next = force_release;
        end else if (hold_reg != {CNT_W{1'b1}}) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      sel_reg     <= 3'd0;
      last_reg    <= 3'd6;
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      sel_reg     <= sel_next;
      last_reg    <= last_next;
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  assign grant    = grant_reg;
  assign sel      = sel_reg;
  assign busy     = (state_reg == GRANT);
  assign hold_cnt = hold_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_seven_way_rr_arbiter.sv
// Directed bench for seven_way_rr_arbiter; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_seven_way_rr_arbiter;

  localparam int CNT_W    = 5;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       req;
  logic             done;
  logic [6:0]       grant;
  logic [2:0]       sel;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout;

  int n_compared = 0;
  int n_failed   = 0;

  seven_way_rr_arbiter #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .sel(sel), .busy(busy), .hold_cnt(hold_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_owner(input string tag, input int idx);
    logic [6:0] oh;
    oh = 7'b0000001 << idx;
    check({tag, ".grant"}, 32'(grant), 32'(oh));
    check({tag, ".sel"},   32'(sel),   32'(idx));
    check({tag, ".busy"},  32'(busy),  32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 7'd0; done = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // reset values
    check_idle("rst");
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.hold", 32'(hold_cnt), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);

    // single requester 0, done in third grant cycle
    req = 7'b0000001;
    tick(); check_owner("s1.g0", 0); check("s1.h0", 32'(hold_cnt), 32'd0);
    tick(); check("s1.h1", 32'(hold_cnt), 32'd1);
    tick(); check("s1.h2", 32'(hold_cnt), 32'd2);
    check_owner("s1.g2", 0);
    done = 1'b1;
    tick(); check_idle("s1.rel");
    done = 1'b0; req = 7'd0;
    tick(); check_idle("s1.idle");

    // all requesting from reset: sel 0..6,0
    reset = 1'b1; tick(); reset = 1'b0;
    req = 7'b1111111;
    for (int k = 0; k < 8; k++) begin
      tick(); check_owner($sformatf("s2.t%0d", k), k % 7);
      check("s2.not7", 32'(sel != 3'b111), 32'd1);
      done = 1'b1;
      tick(); check_idle($sformatf("s2.turn%0d", k));
      done = 1'b0;
      if (k == 7) req = 7'b0001000;
      tick(); check_idle($sformatf("s2.idle%0d", k));
    end

    // owner 3 with 1 and 5 waiting: no preemption, then 5, then 1
    tick(); check_owner("s3.own", 3);
    req = 7'b0101010;
    tick(); check_owner("s3.hold1", 3);
    tick(); check_owner("s3.hold2", 3);
    check("s3.hcnt", 32'(hold_cnt), 32'd2);
    done = 1'b1;
    tick(); check_idle("s3.rel"); done = 1'b0;
    tick(); tick(); check_owner("s3.next5", 5);
    done = 1'b1;
    tick(); done = 1'b0;
    tick(); tick(); check_owner("s3.next1", 1);

    // owner 4 withdraws without done
    done = 1'b1; req = 7'b0010000;
    tick(); done = 1'b0;
    tick(); tick(); check_owner("s4.own4", 4);
    req = 7'd0;
    tick(); check_idle("s4.withdraw");
    req = 7'b1100000;
    tick(); tick(); check_owner("s4.own5", 5);
    tick();
    // reset mid-tenure with done high
    done = 1'b1; reset = 1'b1; req = 7'b1000001;
    tick();
    check_idle("s4.rst");
    check("s4.rst.sel", 32'(sel), 32'd0);
    check("s4.rst.hold", 32'(hold_cnt), 32'd0);
    reset = 1'b0; done = 1'b0;
    tick(); check_owner("s4.after_rst", 0);
    done = 1'b1; req = 7'd0;
    tick(); done = 1'b0;
    tick();

    // sole requester 6 with last=6, then done and req drop together
    reset = 1'b1; tick(); reset = 1'b0;
    req = 7'b1000000;
    tick(); check_owner("s5.own6", 6);
    done = 1'b1; req = 7'd0;
    tick(); check_idle("s5.rel");
    done = 1'b0;
    tick(); check_idle("s5.idle");
    tick(); check_idle("s5.stay");

    // owner 2 never signals done, 4 also waiting
    req = 7'b0010100;
    tick(); check_owner("s6.own2", 2);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < MAX_HOLD; c++) begin
      check_owner($sformatf("s6.c%0d", c), 2);
      check($sformatf("s6.h%0d", c), 32'(hold_cnt), 32'(c));
      check($sformatf("s6.to%0d", c), 32'(timeout), 32'd0);
      tick();
    end
    check_idle("s6.forced");
    check("s6.to_pulse", 32'(timeout), 32'd1);
    tick();
    check("s6.to_clear", 32'(timeout), 32'd0);
    tick(); check_owner("s6.next4", 4);
`else
    for (int c = 0; c < 45; c++) begin
      check_owner($sformatf("s6.c%0d", c), 2);
      check($sformatf("s6.h%0d", c), 32'(hold_cnt), 32'((c > 31) ? 31 : c));
      check($sformatf("s6.to%0d", c), 32'(timeout), 32'd0);
      tick();
    end
    check("s6.sat", 32'(hold_cnt), 32'd31);
    done = 1'b1;
    tick(); check_idle("s6.rel"); done = 1'b0;
    check("s6.to_end", 32'(timeout), 32'd0);
    tick(); tick(); check_owner("s6.next4", 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
